// File: rtl/tap_scan_ctrl_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, instruction opcodes,
// IR capture pattern and data-register select codes.
package tap_scan_ctrl_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST  = 4'b0000;
  localparam logic [3:0] OP_SAMPLE  = 4'b0001;
  localparam logic [3:0] OP_IDCODE  = 4'b0010;
  localparam logic [3:0] OP_INTSCAN = 4'b0100;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    DR_BSCAN,
    DR_INT,
    DR_ID,
    DR_BYP
  } dr_sel_e;

endpackage

// File: rtl/tap_scan_ctrl_fsm.sv
// IEEE 1149.1 16-state TAP controller, advanced by tms on each rising clock.
module tap_fsm
  import tap_scan_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       rst_l,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q, state_d;

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) state_q <= TAP_TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      state_d = TAP_TLR;
    endcase
  end

  always_comb begin
    state = state_q;
  end

endmodule

// File: rtl/tap_scan_ctrl.sv
// JTAG TAP with IR decode, bypass/ID registers and boundary/internal scan controls.
// Build macro TAP_IDCODE_EN adds the 32-bit ID register and the IDCODE instruction.
module tap_scan_ctrl
  import tap_scan_ctrl_pkg::*;
#(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic            clock,
  input  logic            rst_l,
  input  logic            tms,
  input  logic            tdi,
  input  logic            bs_so,
  input  logic            sc_so,
  output logic            tdo,
  output logic            tdo_oe,
  output logic            bs_capture,
  output logic            bs_shift,
  output logic            bs_update,
  output logic            bs_en,
  output logic            sc_sel,
  output logic            sc_capture,
  output logic [IR_W-1:0] ir
);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RST = IR_W'(OP_IDCODE);
`else
  localparam logic [IR_W-1:0] IR_RST = '1;
`endif

  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_chk
    $error("tap_scan_ctrl: IDCODE_VAL[0] must be 1");
  end

  tap_state_e      state;
  dr_sel_e         dr_sel;
  logic            dr_so;
  logic            id_bit;
  logic [IR_W-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic            bypass_q, bypass_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;

  tap_fsm u_fsm (
    .clock (clock),
    .rst_l (rst_l),
    .tms   (tms),
    .state (state)
  );

  always_comb begin
    dr_sel = DR_BYP;
    if (ir_q == IR_W'(OP_EXTEST) || ir_q == IR_W'(OP_SAMPLE)) dr_sel = DR_BSCAN;
    else if (ir_q == IR_W'(OP_INTSCAN))                      dr_sel = DR_INT;
`ifdef TAP_IDCODE_EN
    else if (ir_q == IR_W'(OP_IDCODE))                       dr_sel = DR_ID;
`endif
  end

  always_comb begin
    dr_so = bypass_q;
    unique case (dr_sel)
      DR_BSCAN: dr_so = bs_so;
      DR_INT:   dr_so = sc_so;
      DR_ID:    dr_so = id_bit;
      default:  dr_so = bypass_q;
    endcase
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] id_sr_q, id_sr_d;

  always_comb begin
    id_sr_d = id_sr_q;
    if (state == TAP_TLR) id_sr_d = '0;
    else if (dr_sel == DR_ID && state == TAP_CAP_DR)   id_sr_d = IDCODE_VAL;
    else if (dr_sel == DR_ID && state == TAP_SHIFT_DR) id_sr_d = {tdi, id_sr_q[31:1]};
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) id_sr_q <= '0;
    else        id_sr_q <= id_sr_d;
  end

  always_comb id_bit = id_sr_q[0];
`else
  always_comb id_bit = 1'b0;
`endif

  // TLR rewrites the same values as rst_l so a tms-driven reset is indistinguishable
  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    unique case (state)
      TAP_TLR: begin
        ir_d     = IR_RST;
        ir_sr_d  = '0;
        bypass_d = 1'b0;
      end
      TAP_CAP_IR: ir_sr_d = IR_W'(IR_CAPTURE);
      TAP_SHIFT_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
        ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
      end
      TAP_UPD_IR: ir_d = ir_sr_q;
      TAP_CAP_DR: if (dr_sel == DR_BYP) bypass_d = 1'b0;
      TAP_SHIFT_DR: begin
        tdo_d    = dr_so;
        tdo_oe_d = 1'b1;
        if (dr_sel == DR_BYP) bypass_d = tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      ir_q     <= IR_RST;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  always_comb begin
    bs_capture = 1'b0;
    bs_shift   = 1'b0;
    bs_update  = 1'b0;
    sc_capture = 1'b0;
    sc_sel     = 1'b0;
    unique case (dr_sel)
      DR_BSCAN: begin
        bs_capture = (state == TAP_CAP_DR) || (state == TAP_SHIFT_DR);
        bs_shift   = (state == TAP_SHIFT_DR);
        bs_update  = (state == TAP_UPD_DR);
      end
      DR_INT: begin
        sc_capture = (state == TAP_CAP_DR) || (state == TAP_SHIFT_DR);
        sc_sel     = (state == TAP_SHIFT_DR);
      end
      default: ;
    endcase
    bs_en  = (ir_q == IR_W'(OP_EXTEST));
    tdo    = tdo_q;
    tdo_oe = tdo_oe_q;
    ir     = ir_q;
  end

endmodule
